// File: rtl/output_popcount_if.sv
// Purpose: handshake/data bundle between the beat source and the output_popcount block.
// Latency: none (wires only).
// Backpressure: ready_out stalls the beat source; valid_out is a one-cycle pulse with no backpressure.
// Ports: start, valid_in, x_in[WORD], w_in[10*WORD] (and abort when OUTPUT_POPCOUNT_ABORT_EN)
//        towards the block; ready_out, valid_out, busy, popcount_out_1..10[9] from the block.
interface output_popcount_if #(
    parameter int WORD = 16
);
    logic                 start;
    logic                 valid_in;
    logic [WORD-1:0]      x_in;
    logic [10*WORD-1:0]   w_in;
`ifdef OUTPUT_POPCOUNT_ABORT_EN
    logic                 abort;
`endif
    logic                 ready_out;
    logic                 valid_out;
    logic                 busy;
    logic [8:0]           popcount_out_1;
    logic [8:0]           popcount_out_2;
    logic [8:0]           popcount_out_3;
    logic [8:0]           popcount_out_4;
    logic [8:0]           popcount_out_5;
    logic [8:0]           popcount_out_6;
    logic [8:0]           popcount_out_7;
    logic [8:0]           popcount_out_8;
    logic [8:0]           popcount_out_9;
    logic [8:0]           popcount_out_10;

    modport master (
        output start, valid_in, x_in, w_in,
`ifdef OUTPUT_POPCOUNT_ABORT_EN
        output abort,
`endif
        input  ready_out, valid_out, busy,
        input  popcount_out_1, popcount_out_2, popcount_out_3, popcount_out_4, popcount_out_5,
        input  popcount_out_6, popcount_out_7, popcount_out_8, popcount_out_9, popcount_out_10
    );

    modport slave (
        input  start, valid_in, x_in, w_in,
`ifdef OUTPUT_POPCOUNT_ABORT_EN
        input  abort,
`endif
        output ready_out, valid_out, busy,
        output popcount_out_1, popcount_out_2, popcount_out_3, popcount_out_4, popcount_out_5,
        output popcount_out_6, popcount_out_7, popcount_out_8, popcount_out_9, popcount_out_10
    );
endinterface

// File: rtl/output_popcount.sv
// Purpose: XNOR-popcount accumulation of BEATS binarized beats for 10 output neurons.
// Latency: results load on the edge accepting the last beat; valid_out pulses the next cycle.
// Backpressure: ready_out high only in ACCUM; valid_in is ignored elsewhere.
// Ports: clk, rst_n (async active-low), bus (output_popcount_if.slave).
// Optional feature: define OUTPUT_POPCOUNT_ABORT_EN to add bus.abort, which drops an
// inference in ACCUM/EMIT back to IDLE while keeping the previous popcount_out_* values.
module output_popcount #(
    parameter int WORD  = 16,
    parameter int BEATS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    output_popcount_if.slave    bus
);
    // Accumulators are 9 bits wide, so the total number of compared bits must fit.
    if (WORD * BEATS > 511) begin : g_size_check
        $error("output_popcount: WORD*BEATS must be <= 511");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    localparam logic [8:0] LAST_BEAT = 9'(BEATS - 1);

    state_t     state;
    logic [8:0] beat_cnt;
    logic [8:0] acc     [10];
    logic [8:0] pc_q    [10];
    logic [8:0] contrib [10];
    logic       ready_q;
    logic       valid_q;
    logic       busy_q;
    logic       abort;

`ifdef OUTPUT_POPCOUNT_ABORT_EN
    assign abort = bus.abort;
`else
    assign abort = 1'b0;
`endif

    // Per-neuron contribution of the current beat: number of positions where
    // activation and weight agree (XNOR), i.e. 0..WORD.
    always_comb begin
        for (int k = 0; k < 10; k++) begin
            contrib[k] = '0;
            for (int b = 0; b < WORD; b++) begin
                contrib[k] = contrib[k] + {8'd0, ~(bus.x_in[b] ^ bus.w_in[k*WORD + b])};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            for (int k = 0; k < 10; k++) begin
                acc[k]  <= '0;
                pc_q[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    // A beat presented together with start is deliberately not taken.
                    if (bus.start) begin
                        state    <= ACCUM;
                        beat_cnt <= '0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        for (int k = 0; k < 10; k++) acc[k] <= '0;
                    end
                end
                ACCUM: begin
                    if (abort) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b0;
                        for (int k = 0; k < 10; k++) acc[k] <= '0;
                    end else if (bus.valid_in) begin
                        if (beat_cnt == LAST_BEAT) begin
                            // Final sum bypasses the accumulator straight to the outputs.
                            state   <= EMIT;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                            for (int k = 0; k < 10; k++) pc_q[k] <= acc[k] + contrib[k];
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                            for (int k = 0; k < 10; k++) acc[k] <= acc[k] + contrib[k];
                        end
                    end
                end
                EMIT: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (abort) begin
                        beat_cnt <= '0;
                        for (int k = 0; k < 10; k++) acc[k] <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_out       = ready_q;
    assign bus.valid_out       = valid_q;
    assign bus.busy            = busy_q;
    assign bus.popcount_out_1  = pc_q[0];
    assign bus.popcount_out_2  = pc_q[1];
    assign bus.popcount_out_3  = pc_q[2];
    assign bus.popcount_out_4  = pc_q[3];
    assign bus.popcount_out_5  = pc_q[4];
    assign bus.popcount_out_6  = pc_q[5];
    assign bus.popcount_out_7  = pc_q[6];
    assign bus.popcount_out_8  = pc_q[7];
    assign bus.popcount_out_9  = pc_q[8];
    assign bus.popcount_out_10 = pc_q[9];
endmodule

// File: tb/tb_output_popcount.sv
// Purpose: directed self-checking bench for output_popcount with a result scoreboard.
// Latency: expects results and a valid_out pulse one cycle after the last accepted beat.
// Backpressure: drives beats only while the block is in ACCUM; gaps exercise valid_in low.
module tb_output_popcount;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [89:0] sb_q [$];
    logic [89:0] last_exp;

    output_popcount_if #(.WORD(16)) bus ();

    output_popcount #(.WORD(16), .BEATS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [89:0] outs();
        return {bus.popcount_out_10, bus.popcount_out_9, bus.popcount_out_8, bus.popcount_out_7,
                bus.popcount_out_6, bus.popcount_out_5, bus.popcount_out_4, bus.popcount_out_3,
                bus.popcount_out_2, bus.popcount_out_1};
    endfunction

    function automatic logic [159:0] rnd_w();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode 0: every neuron's weights equal x; 1: x=0, weights all ones;
    // 2: neuron 5 equals x, others x^00FF; 3: fully random.
    task automatic gen(input int mode, output logic [15:0] x, output logic [159:0] w);
        x = 16'($urandom);
        case (mode)
            0: w = {10{x}};
            1: begin x = 16'h0000; w = {160{1'b1}}; end
            2: begin w = {10{x ^ 16'h00FF}}; w[4*16 +: 16] = x; end
            default: w = rnd_w();
        endcase
    endtask

    function automatic logic [89:0] add_beat(input logic [89:0] e, input logic [15:0] x,
                                             input logic [159:0] w);
        logic [89:0] r;
        r = e;
        for (int k = 0; k < 10; k++)
            r[k*9 +: 9] = r[k*9 +: 9] + 9'($countones(~(x ^ w[k*16 +: 16])));
        return r;
    endfunction

    task automatic compare_outputs(input string tag);
        logic [89:0] got;
        logic [89:0] exp;
        got = outs();
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb_q.size()), 1);
        end else begin
            exp = sb_q.pop_front();
            last_exp = exp;
            for (int k = 0; k < 10; k++)
                chk($sformatf("%s_n%0d", tag, k + 1), 32'(got[k*9 +: 9]), 32'(exp[k*9 +: 9]));
        end
    endtask

    task automatic run_inf(input string tag, input int mode, input bit gap, input bit hold);
        logic [15:0]  x;
        logic [159:0] w;
        logic [89:0]  e;
        bit           vo_seen;
        e = '0;
        vo_seen = 1'b0;
        bus.start = 1'b1;
        if (hold) begin
            // Beat presented with start must not be counted.
            bus.valid_in = 1'b1;
            bus.x_in = 16'h0000;
            bus.w_in = '0;
        end
        tick();
        if (!hold) bus.start = 1'b0;
        for (int b = 0; b < 16; b++) begin
            if (gap) begin
                bus.valid_in = 1'b0;
                bus.x_in = 16'($urandom);
                bus.w_in = rnd_w();
                tick();
                vo_seen |= bus.valid_out;
            end
            gen(mode, x, w);
            bus.valid_in = 1'b1;
            bus.x_in = x;
            bus.w_in = w;
            e = add_beat(e, x, w);
            if (b == 15) sb_q.push_back(e);
            tick();
            if (b < 15) vo_seen |= bus.valid_out;
        end
        if (hold) begin
            bus.x_in = 16'h0000;
            bus.w_in = '0;
        end else begin
            bus.valid_in = 1'b0;
        end
        chk({tag, "_no_early_valid"}, 32'(vo_seen), 0);
        chk({tag, "_valid_emit"}, 32'(bus.valid_out), 1);
        compare_outputs(tag);
        tick();
        bus.start = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.valid_out), 0);
        chk({tag, "_busy_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        logic [15:0]  x;
        logic [159:0] w;
        bit           vo_seen;
        tests = 0;
        fails = 0;
        last_exp = '0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.valid_in = 1'b0;
        bus.x_in = '0;
        bus.w_in = '0;
`ifdef OUTPUT_POPCOUNT_ABORT_EN
        bus.abort = 1'b0;
`endif
        tick();
        tick();
        chk("rst_outs", 32'(outs() != '0), 0);
        chk("rst_valid", 32'(bus.valid_out), 0);
        chk("rst_ready", 32'(bus.ready_out), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        tick();

        // Matching weights -> 256 everywhere.
        run_inf("equal", 0, 1'b0, 1'b0);
        // All-mismatch, then neuron 5 matching and others half matching.
        run_inf("zero", 1, 1'b0, 1'b0);
        run_inf("half", 2, 1'b0, 1'b0);
        run_inf("random", 3, 1'b0, 1'b0);
        // Alternate-cycle gaps.
        run_inf("gaps", 0, 1'b1, 1'b0);

        // ready_out/busy while accumulating, then reset after 8 beats.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("accum_ready", 32'(bus.ready_out), 1);
        chk("accum_busy", 32'(bus.busy), 1);
        for (int b = 0; b < 8; b++) begin
            gen(0, x, w);
            bus.valid_in = 1'b1;
            bus.x_in = x;
            bus.w_in = w;
            tick();
        end
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", 32'(outs() != '0), 0);
        chk("midrst_valid", 32'(bus.valid_out), 0);
        chk("midrst_ready", 32'(bus.ready_out), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        tick();
        rst_n = 1'b1;
        vo_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vo_seen |= bus.valid_out;
        end
        chk("midrst_no_valid", 32'(vo_seen), 0);
        run_inf("after_rst", 2, 1'b0, 1'b0);

        // start held high through ACCUM/EMIT, valid_in high in IDLE.
        bus.valid_in = 1'b1;
        bus.x_in = 16'h1234;
        bus.w_in = {10{16'h1234}};
        tick();
        tick();
        chk("idle_beat_ignored_busy", 32'(bus.busy), 0);
        chk("idle_beat_outs_held", 32'(bus.popcount_out_1), 32'(last_exp[0 +: 9]));
        run_inf("hold", 0, 1'b0, 1'b1);
        vo_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vo_seen |= bus.valid_out | bus.busy;
        end
        bus.valid_in = 1'b0;
        chk("hold_no_restart", 32'(vo_seen), 0);
        chk("hold_out1_kept", 32'(bus.popcount_out_1), 256);
        chk("hold_out10_kept", 32'(bus.popcount_out_10), 256);

`ifdef OUTPUT_POPCOUNT_ABORT_EN
        run_inf("pre_abort", 2, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            gen(0, x, w);
            bus.valid_in = 1'b1;
            bus.x_in = x;
            bus.w_in = w;
            tick();
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.valid_in = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_valid", 32'(bus.valid_out), 0);
        chk("abort_out5_kept", 32'(bus.popcount_out_5), 32'(last_exp[4*9 +: 9]));
        chk("abort_out1_kept", 32'(bus.popcount_out_1), 32'(last_exp[0 +: 9]));
        run_inf("post_abort", 0, 1'b0, 1'b0);
`endif

        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
